// File: rtl/simple_ram.sv
// simple_ram: 1R/1W synchronous RAM with per-byte write mask and registered, held read data.
// Optional build macro SIMPLE_RAM_BYPASS_EN: same-address collisions forward write data (write-first).
module simple_ram #(
    parameter int unsigned AddrBusWidth     = 5,
    parameter int unsigned DataBusByteWidth = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            read_flag,
    input  logic [AddrBusWidth-1:0]         read_addr,
    input  logic                            write_flag,
    input  logic [8*DataBusByteWidth-1:0]   write_data,
    input  logic [AddrBusWidth-1:0]         write_addr,
    input  logic [DataBusByteWidth-1:0]     write_mask,
    output logic [8*DataBusByteWidth-1:0]   read_data
);

    localparam int unsigned ByteWidth = 8;
    localparam int unsigned DataWidth = ByteWidth * DataBusByteWidth;
    localparam int unsigned Depth     = 1 << AddrBusWidth;

    // No reset on the array so it maps onto block RAM.
    logic [DataWidth-1:0] mem [Depth];
    logic [DataWidth-1:0] read_word_c;

    // Byte-masked write port; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && write_flag) begin
            for (int unsigned i = 0; i < DataBusByteWidth; i++) begin
                if (write_mask[i]) begin
                    mem[write_addr][ByteWidth*i +: ByteWidth] <= write_data[ByteWidth*i +: ByteWidth];
                end
            end
        end
    end

`ifdef SIMPLE_RAM_BYPASS_EN
    // Write-first: merge masked-in write bytes over the stored word on an address match.
    always_comb begin
        read_word_c = mem[read_addr];
        if (write_flag && (write_addr == read_addr)) begin
            for (int unsigned i = 0; i < DataBusByteWidth; i++) begin
                if (write_mask[i]) begin
                    read_word_c[ByteWidth*i +: ByteWidth] = write_data[ByteWidth*i +: ByteWidth];
                end
            end
        end
    end
`else
    // Read-first: a colliding read sees the contents from before this edge's write.
    always_comb begin
        read_word_c = mem[read_addr];
    end
`endif

    // Read register holds its value until the next read or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data <= '0;
        end else if (read_flag) begin
            read_data <= read_word_c;
        end
    end

endmodule

// File: tb/tb_simple_ram.sv
// Directed, table-driven bench for simple_ram: default 32x32 instance plus a 4x8 parameter variant.
module tb_simple_ram;

    logic        clk;
    logic        rst;
    logic        read_flag;
    logic [4:0]  read_addr;
    logic        write_flag;
    logic [31:0] write_data;
    logic [4:0]  write_addr;
    logic [3:0]  write_mask;
    logic [31:0] read_data;

    logic        s_read_flag;
    logic [1:0]  s_read_addr;
    logic        s_write_flag;
    logic [7:0]  s_write_data;
    logic [1:0]  s_write_addr;
    logic [0:0]  s_write_mask;
    logic [7:0]  s_read_data;

    int total = 0;
    int bad   = 0;

    simple_ram u_dut (
        .clk        (clk),
        .rst        (rst),
        .read_flag  (read_flag),
        .read_addr  (read_addr),
        .write_flag (write_flag),
        .write_data (write_data),
        .write_addr (write_addr),
        .write_mask (write_mask),
        .read_data  (read_data)
    );

    simple_ram #(
        .AddrBusWidth     (2),
        .DataBusByteWidth (1)
    ) u_small (
        .clk        (clk),
        .rst        (rst),
        .read_flag  (s_read_flag),
        .read_addr  (s_read_addr),
        .write_flag (s_write_flag),
        .write_data (s_write_data),
        .write_addr (s_write_addr),
        .write_mask (s_write_mask),
        .read_data  (s_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [4:0]  raddr;
        logic        wr;
        logic [31:0] wdata;
        logic [4:0]  waddr;
        logic [3:0]  wmask;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic [4:0] raddr, input logic wr,
                         input logic [31:0] wdata, input logic [4:0] waddr, input logic [3:0] wmask);
        read_flag  = rd;
        read_addr  = raddr;
        write_flag = wr;
        write_data = wdata;
        write_addr = waddr;
        write_mask = wmask;
    endtask

    task automatic sdrive(input logic rd, input logic [1:0] raddr, input logic wr,
                          input logic [7:0] wdata, input logic [1:0] waddr, input logic wmask);
        s_read_flag  = rd;
        s_read_addr  = raddr;
        s_write_flag = wr;
        s_write_data = wdata;
        s_write_addr = waddr;
        s_write_mask = wmask;
    endtask

    // Advance one rising edge and sample just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] collide_exp;

        vecs[0] = '{1'b0, 5'd0, 1'b1, 32'h11223344, 5'd3, 4'b1111, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 5'd0, 1'b1, 32'hAABBCCDD, 5'd3, 4'b0101, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd3, 1'b0, 32'h00000000, 5'd0, 4'b0000, 32'h11BB33DD};
        vecs[3] = '{1'b1, 5'd3, 1'b1, 32'hCAFEF00D, 5'd5, 4'b1111, 32'h11BB33DD};
        vecs[4] = '{1'b1, 5'd5, 1'b1, 32'hFFFFFFFF, 5'd3, 4'b0000, 32'hCAFEF00D};
        vecs[5] = '{1'b1, 5'd3, 1'b1, 32'h00123456, 5'd5, 4'b1000, 32'h11BB33DD};
        vecs[6] = '{1'b1, 5'd5, 1'b0, 32'h00000000, 5'd0, 4'b0000, 32'h00FEF00D};
        vecs[7] = '{1'b0, 5'd5, 1'b0, 32'h00000000, 5'd0, 4'b0000, 32'h00FEF00D};

        drive(1'b0, 5'd0, 1'b0, 32'h0, 5'd0, 4'b0);
        sdrive(1'b0, 2'd0, 1'b0, 8'h0, 2'd0, 1'b0);
        rst = 1'b1;
        repeat (2) tick();
        check("reset_value", read_data, 32'h0);
        check("reset_value_small", {24'h0, s_read_data}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Reset: async clear mid-cycle, ops during reset ignored.
        drive(1'b0, 5'd0, 1'b1, 32'hDEADBEEF, 5'd1, 4'b1111);
        tick();
        drive(1'b1, 5'd1, 1'b0, 32'h0, 5'd0, 4'b0);
        tick();
        check("read_deadbeef", read_data, 32'hDEADBEEF);
        drive(1'b0, 5'd0, 1'b0, 32'h0, 5'd0, 4'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_midcycle", read_data, 32'h0);
        drive(1'b1, 5'd1, 1'b1, 32'h00000000, 5'd1, 4'b1111);
        tick();
        check("read_during_reset", read_data, 32'h0);
        tick();
        check("read_during_reset2", read_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 5'd1, 1'b0, 32'h0, 5'd0, 4'b0);
        tick();
        check("write_dropped_in_reset", read_data, 32'hDEADBEEF);

        // Table: masked writes, concurrent different-address ops, mask-0 no-op, hold.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].rd, vecs[i].raddr, vecs[i].wr, vecs[i].wdata, vecs[i].waddr, vecs[i].wmask);
            tick();
            check($sformatf("vec%0d", i), read_data, vecs[i].exp);
        end

        // Hold for 10 cycles while overwriting the address last read.
        drive(1'b1, 5'd3, 1'b0, 32'h0, 5'd0, 4'b0);
        tick();
        check("hold_setup", read_data, 32'h11BB33DD);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 5'd3, 1'b1, 32'h00000000, 5'd3, 4'b1111);
            tick();
            check($sformatf("hold%0d", i), read_data, 32'h11BB33DD);
        end
        drive(1'b1, 5'd3, 1'b0, 32'h0, 5'd0, 4'b0);
        tick();
        check("hold_after_write", read_data, 32'h0);

        // Back-to-back: fill every word, then stream reads.
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 5'd0, 1'b1, 32'h100 + 32'(a), 5'(a), 4'b1111);
            tick();
        end
        for (int a = 0; a < 32; a++) begin
            drive(1'b1, 5'(a), 1'b0, 32'h0, 5'd0, 4'b0);
            tick();
            check($sformatf("b2b_addr%0d", a), read_data, 32'h100 + 32'(a));
        end

        // Collision on addr 7.
`ifdef SIMPLE_RAM_BYPASS_EN
        collide_exp = 32'h0102F0F0;
`else
        collide_exp = 32'h01020304;
`endif
        drive(1'b0, 5'd0, 1'b1, 32'h01020304, 5'd7, 4'b1111);
        tick();
        drive(1'b1, 5'd7, 1'b1, 32'hF0F0F0F0, 5'd7, 4'b0011);
        tick();
        check("collision_same_cycle", read_data, collide_exp);
        drive(1'b1, 5'd7, 1'b0, 32'h0, 5'd0, 4'b0);
        tick();
        check("collision_next_read", read_data, 32'h0102F0F0);
        drive(1'b0, 5'd0, 1'b0, 32'h0, 5'd0, 4'b0);

        // 4x8 variant: no aliasing between addr 0 and 3, mask-0 no-op.
        sdrive(1'b0, 2'd0, 1'b1, 8'h5A, 2'd0, 1'b1);
        tick();
        sdrive(1'b0, 2'd0, 1'b1, 8'hA5, 2'd3, 1'b1);
        tick();
        sdrive(1'b0, 2'd0, 1'b1, 8'h33, 2'd1, 1'b1);
        tick();
        sdrive(1'b1, 2'd0, 1'b1, 8'hCC, 2'd1, 1'b0);
        tick();
        check("small_addr0", {24'h0, s_read_data}, 32'h5A);
        sdrive(1'b1, 2'd3, 1'b0, 8'h00, 2'd0, 1'b0);
        tick();
        check("small_addr3", {24'h0, s_read_data}, 32'hA5);
        sdrive(1'b1, 2'd1, 1'b0, 8'h00, 2'd0, 1'b0);
        tick();
        check("small_mask0_noop", {24'h0, s_read_data}, 32'h33);
        sdrive(1'b0, 2'd0, 1'b0, 8'h00, 2'd0, 1'b0);
        tick();
        check("small_hold", {24'h0, s_read_data}, 32'h33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
